// File: rtl/demux1to5_reg_if.sv
// Bus bundle for the registered 1-to-5 write-side demultiplexer.
// The master drives the write/ack side and the slave (the demux) returns the holding registers and flags.
interface demux1to5_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic [2:0]       selector;
  logic             wr_en;
  logic [WIDTH-1:0] Data_in;
  logic [4:0]       rd_ack;
  logic [WIDTH-1:0] Data_0;
  logic [WIDTH-1:0] Data_1;
  logic [WIDTH-1:0] Data_2;
  logic [WIDTH-1:0] Data_3;
  logic [WIDTH-1:0] Data_4;
  logic [4:0]       valid;
  logic             overrun;
  logic             sel_err;
  logic             err_sticky;
  logic [CNT_W-1:0] wr_count;

  modport master (
    output selector, wr_en, Data_in, rd_ack,
    input  Data_0, Data_1, Data_2, Data_3, Data_4,
    input  valid, overrun, sel_err, err_sticky, wr_count
  );

  modport slave (
    input  selector, wr_en, Data_in, rd_ack,
    output Data_0, Data_1, Data_2, Data_3, Data_4,
    output valid, overrun, sel_err, err_sticky, wr_count
  );
endinterface

// File: rtl/demux1to5_reg.sv
// Registered 1-to-5 demultiplexer: steers the result bus into one of five holding registers
// with per-slot valid flags, overrun/illegal-selector pulses, a sticky error and a write counter.
module demux1to5_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  demux1to5_reg_if.slave    bus
);

  logic [WIDTH-1:0] r_data [5];
  logic [4:0]       r_valid;
  logic             r_overrun;
  logic             r_selErr;
  logic             r_errSticky;
  logic [CNT_W-1:0] r_wrCount;

  logic             w_accept;
  logic             w_selErr;
  logic             w_overrun;
  logic [4:0]       w_selHot;

  always_comb begin
    w_accept = bus.wr_en && (bus.selector <= 3'd4);
    w_selErr = bus.wr_en && (bus.selector > 3'd4);
    w_selHot = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      w_selHot[i] = w_accept && (bus.selector == 3'(i));
    end
    // An ack on the written slot in the same cycle means the old data was consumed.
    w_overrun = |(w_selHot & r_valid & ~bus.rd_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        r_data[i] <= '0;
      end
      r_valid     <= 5'b00000;
      r_overrun   <= 1'b0;
      r_selErr    <= 1'b0;
      r_errSticky <= 1'b0;
      r_wrCount   <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (w_selHot[i]) begin
          r_data[i] <= bus.Data_in;
        end
      end
      // Write sets after ack clears, so a same-slot write and ack leaves the slot valid.
      r_valid     <= (r_valid & ~bus.rd_ack) | w_selHot;
      r_overrun   <= w_overrun;
      r_selErr    <= w_selErr;
      r_errSticky <= r_errSticky | w_overrun | w_selErr;
      if (w_accept) begin
        r_wrCount <= r_wrCount + 1'b1;
      end
    end
  end

  assign bus.Data_0     = r_data[0];
  assign bus.Data_1     = r_data[1];
  assign bus.Data_2     = r_data[2];
  assign bus.Data_3     = r_data[3];
  assign bus.Data_4     = r_data[4];
  assign bus.valid      = r_valid;
  assign bus.overrun    = r_overrun;
  assign bus.sel_err    = r_selErr;
  assign bus.err_sticky = r_errSticky;
  assign bus.wr_count   = r_wrCount;

endmodule

// File: tb/tb_demux1to5_reg.sv
// Scoreboard bench for demux1to5_reg: the driver pushes the expected post-edge state from a
// slot-level reference model, and an independent monitor pops and compares after every edge.
module tb_demux1to5_reg;

  typedef struct packed {
    logic [4:0][31:0] data;
    logic [4:0]       valid;
    logic             overrun;
    logic             selErr;
    logic             sticky;
    logic [7:0]       count;
  } expT;

  logic clk;
  logic reset;
  demux1to5_reg_if #(.WIDTH(32), .CNT_W(8)) bus ();

  demux1to5_reg #(.WIDTH(32), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  expT         expQ[$];
  int          nTests = 0;
  int          nFail  = 0;
  int          cycleNo = 0;

  logic [31:0] mData [5];
  bit   [4:0]  mValid;
  bit          mSticky;
  int          mCount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    nTests++;
    if (act !== want) begin
      nFail++;
      $display("[TB] FAIL cycle %0d %s: got %h, expected %h", cycleNo, name, act, want);
    end
  endtask

  task automatic checkOutput(input expT e);
    check32("Data_0", bus.Data_0, e.data[0]);
    check32("Data_1", bus.Data_1, e.data[1]);
    check32("Data_2", bus.Data_2, e.data[2]);
    check32("Data_3", bus.Data_3, e.data[3]);
    check32("Data_4", bus.Data_4, e.data[4]);
    check32("valid", 32'(bus.valid), 32'(e.valid));
    check32("overrun", 32'(bus.overrun), 32'(e.overrun));
    check32("sel_err", 32'(bus.sel_err), 32'(e.selErr));
    check32("err_sticky", 32'(bus.err_sticky), 32'(e.sticky));
    check32("wr_count", 32'(bus.wr_count), 32'(e.count));
  endtask

  // Drive one cycle, advance the reference model by the slot rules, and queue the expected result.
  task automatic applyStimulus(input bit rst, input bit we, input int sel,
                               input logic [31:0] din, input logic [4:0] ack);
    expT e;
    bit  ovr;
    bit  se;
    reset        = rst;
    bus.wr_en    = we;
    bus.selector = 3'(sel);
    bus.Data_in  = din;
    bus.rd_ack   = ack;
    ovr = 1'b0;
    se  = 1'b0;
    if (rst) begin
      for (int i = 0; i < 5; i++) mData[i] = 32'h0;
      mValid  = 5'b00000;
      mSticky = 1'b0;
      mCount  = 0;
    end else begin
      if (we && sel <= 4) begin
        ovr = mValid[sel] && !ack[sel];
        mValid = mValid & ~ack;
        mValid[sel] = 1'b1;
        mData[sel]  = din;
        mCount = (mCount + 1) % 256;
      end else begin
        se = we;
        mValid = mValid & ~ack;
      end
      mSticky = mSticky | ovr | se;
    end
    for (int i = 0; i < 5; i++) e.data[i] = mData[i];
    e.valid   = mValid;
    e.overrun = ovr;
    e.selErr  = se;
    e.sticky  = mSticky;
    e.count   = 8'(mCount);
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 32'h0, 5'b00000);
  endtask

  always @(posedge clk) begin
    expT e;
    #2;
    cycleNo++;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          rst;
    bit          we;
    int          sel;
    logic [4:0]  ack;

    // Reset dominates an active write.
    applyStimulus(1'b1, 1'b1, 2, 32'hDEADBEEF, 5'b00000);
    applyStimulus(1'b1, 1'b1, 2, 32'hDEADBEEF, 5'b00000);

    // Routing to every slot on consecutive cycles.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, i, 32'h11111111 * (i + 1), 5'b00000);
    end
    idle(1);

    // Overrun without ack, then the same write with a same-slot ack.
    applyStimulus(1'b1, 1'b0, 0, 32'h0, 5'b00000);
    applyStimulus(1'b0, 1'b1, 3, 32'hA, 5'b00000);
    applyStimulus(1'b0, 1'b1, 3, 32'hB, 5'b00000);
    idle(2);
    applyStimulus(1'b1, 1'b0, 0, 32'h0, 5'b00000);
    applyStimulus(1'b0, 1'b1, 3, 32'hA, 5'b00000);
    applyStimulus(1'b0, 1'b1, 3, 32'hB, 5'b01000);
    idle(1);

    // Illegal selector, then back-to-back illegal writes.
    applyStimulus(1'b0, 1'b1, 6, 32'hFFFFFFFF, 5'b00000);
    idle(1);
    applyStimulus(1'b0, 1'b1, 5, 32'h12345678, 5'b00000);
    applyStimulus(1'b0, 1'b1, 7, 32'h87654321, 5'b00000);
    idle(1);

    // Consume two slots at once; data must survive.
    applyStimulus(1'b1, 1'b0, 0, 32'h0, 5'b00000);
    applyStimulus(1'b0, 1'b1, 0, 32'hC0C0C0C0, 5'b00000);
    applyStimulus(1'b0, 1'b1, 4, 32'h4444AAAA, 5'b00000);
    applyStimulus(1'b0, 1'b0, 0, 32'h0, 5'b10001);
    applyStimulus(1'b0, 1'b0, 0, 32'h0, 5'b10001);
    idle(1);

    // Write to one slot while acking a different one.
    applyStimulus(1'b0, 1'b1, 1, 32'h1, 5'b00000);
    applyStimulus(1'b0, 1'b1, 2, 32'h2, 5'b00010);
    idle(1);

    // Counter wrap with every slot acked each cycle so nothing overruns.
    applyStimulus(1'b1, 1'b0, 0, 32'h0, 5'b00000);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 1'b1, i % 5, $urandom, 5'b11111);
    end
    idle(2);

    // Randomized traffic including occasional resets and illegal selectors.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      we  = ($urandom_range(0, 3) != 0);
      sel = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
      ack = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b00000;
      applyStimulus(rst, we, sel, $urandom, ack);
    end
    idle(1);

    repeat (3) @(posedge clk);
    #3;
    nTests++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("[TB] FAIL scoreboard drain: got %0d entries left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
